// File: rtl/axi_lite_pkg.sv
// AXI4-Lite response codes and poller FSM encodings.
// Shared by the status poller and its timer.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/poll_timer.sv
// Reloadable down-counter that parks at zero.
// Load has priority over the decrement.
module poll_timer #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/axi_status_poller.sv
// AXI4-Lite read-only master polling one status register.
// Publishes the last good word, change pulses and an error count.
module axi_status_poller
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] POLL_ADDR   = 32'h0000_0000,
  parameter int unsigned POLL_CYCLES = 1000,
  parameter int          ERR_W       = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             poll_now,
  output logic [31:0]      status_word,
  output logic             status_valid,
  output logic             status_changed,
  output logic             rd_error,
  output logic [ERR_W-1:0] err_count,
  output logic             busy,
  output logic [31:0]      M_AXI_ARADDR,
  output logic             M_AXI_ARVALID,
  output logic [2:0]       M_AXI_ARPROT,
  input  logic             M_AXI_ARREADY,
  input  logic [31:0]      M_AXI_RDATA,
  input  logic [1:0]       M_AXI_RRESP,
  input  logic             M_AXI_RVALID,
  output logic             M_AXI_RREADY,
  output logic [31:0]      M_AXI_AWADDR,
  output logic             M_AXI_AWVALID,
  output logic [2:0]       M_AXI_AWPROT,
  output logic [31:0]      M_AXI_WDATA,
  output logic [3:0]       M_AXI_WSTRB,
  output logic             M_AXI_WVALID,
  input  logic             M_AXI_AWREADY,
  input  logic             M_AXI_WREADY,
  input  logic [1:0]       M_AXI_BRESP,
  input  logic             M_AXI_BVALID,
  output logic             M_AXI_BREADY
);

  localparam logic [23:0] RELOAD = 24'(POLL_CYCLES - 1);

  logic [1:0] state;
  logic       pending;
  logic       tmr_zero;
  logic       trigger;
  logic       ar_hs;
  logic       r_hs;

  assign M_AXI_ARADDR  = POLL_ADDR;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = (state == ST_ADDR);
  assign M_AXI_RREADY  = (state == ST_DATA);
  assign busy          = (state != ST_IDLE);

  assign M_AXI_AWADDR  = '0;
  assign M_AXI_AWVALID = 1'b0;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_WDATA   = '0;
  assign M_AXI_WSTRB   = '0;
  assign M_AXI_WVALID  = 1'b0;
  assign M_AXI_BREADY  = 1'b1;

  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_AWREADY, M_AXI_WREADY,
                           M_AXI_BRESP, M_AXI_BVALID};

  assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID && M_AXI_RREADY;

  assign trigger = (state == ST_IDLE) &&
                   ((enable && tmr_zero) || poll_now || pending);

  poll_timer #(
    .W(24)
  ) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .load    (r_hs),
    .load_val(RELOAD),
    .zero    (tmr_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (trigger) state <= ST_ADDR;
        ST_ADDR: if (ar_hs) state <= ST_DATA;
        ST_DATA: if (r_hs) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // one queued request at most; extra pulses while busy merge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending <= 1'b0;
    end else if (trigger) begin
      pending <= 1'b0;
    end else if (poll_now && state != ST_IDLE) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_word    <= '0;
      status_valid   <= 1'b0;
      status_changed <= 1'b0;
      rd_error       <= 1'b0;
      err_count      <= '0;
    end else begin
      status_changed <= 1'b0;
      rd_error       <= 1'b0;
      if (r_hs) begin
        if (M_AXI_RRESP == RESP_OKAY) begin
          status_word    <= M_AXI_RDATA;
          status_valid   <= 1'b1;
          status_changed <= !status_valid ||
                            (M_AXI_RDATA != status_word);
        end else begin
          rd_error <= 1'b1;
          if (err_count != '1) err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_status_poller.sv
// Directed bench for axi_status_poller with a delay-programmable slave.
// A second instance with ERR_W=2 shadows the first for saturation.
module tb_axi_status_poller;
  import axi_lite_pkg::*;

  localparam logic [31:0] ADDR = 32'h0000_0040;
  localparam int unsigned PC   = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        poll_now;
  logic [31:0] status_word;
  logic        status_valid;
  logic        status_changed;
  logic        rd_error;
  logic [15:0] err_count;
  logic        busy;
  logic [31:0] araddr;
  logic        arvalid;
  logic [2:0]  arprot;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [2:0]  awprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        bready;

  logic [31:0] s2_word;
  logic        s2_valid, s2_chg, s2_err, s2_busy;
  logic [1:0]  s2_cnt;
  logic [31:0] s2_araddr, s2_awaddr, s2_wdata;
  logic        s2_arvalid, s2_rready, s2_awvalid, s2_wvalid, s2_bready;
  logic [2:0]  s2_arprot, s2_awprot;
  logic [3:0]  s2_wstrb;

  axi_status_poller #(
    .POLL_ADDR(ADDR), .POLL_CYCLES(PC), .ERR_W(16)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .poll_now(poll_now),
    .status_word(status_word), .status_valid(status_valid),
    .status_changed(status_changed), .rd_error(rd_error),
    .err_count(err_count), .busy(busy),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARPROT(arprot), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWPROT(awprot), .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_AWREADY(1'b0), .M_AXI_WREADY(1'b0),
    .M_AXI_BRESP(2'b00), .M_AXI_BVALID(1'b0),
    .M_AXI_BREADY(bready)
  );

  axi_status_poller #(
    .POLL_ADDR(ADDR), .POLL_CYCLES(PC), .ERR_W(2)
  ) dut2 (
    .clk(clk), .resetn(resetn), .enable(enable), .poll_now(poll_now),
    .status_word(s2_word), .status_valid(s2_valid),
    .status_changed(s2_chg), .rd_error(s2_err),
    .err_count(s2_cnt), .busy(s2_busy),
    .M_AXI_ARADDR(s2_araddr), .M_AXI_ARVALID(s2_arvalid),
    .M_AXI_ARPROT(s2_arprot), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(s2_rready),
    .M_AXI_AWADDR(s2_awaddr), .M_AXI_AWVALID(s2_awvalid),
    .M_AXI_AWPROT(s2_awprot), .M_AXI_WDATA(s2_wdata),
    .M_AXI_WSTRB(s2_wstrb), .M_AXI_WVALID(s2_wvalid),
    .M_AXI_AWREADY(1'b0), .M_AXI_WREADY(1'b0),
    .M_AXI_BRESP(2'b00), .M_AXI_BVALID(1'b0),
    .M_AXI_BREADY(s2_bready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // slave config
  int          ar_delay = 0;
  int          r_delay  = 0;
  logic [31:0] cfg_data = 32'h31;
  logic [1:0]  cfg_resp = RESP_OKAY;
  int          ar_wait  = 0;
  int          r_wait   = 0;

  // monitor state
  int cyc = 0;
  int ar_rises = 0, r_hs = 0, chg_cnt = 0, err_pulses = 0;
  int ar_rise_cyc = 0, r_hs_cyc = 0, ar_gap = 0;
  int ar_len = 0, r_len = 0, addr_bad = 0, rr_gap = 0;
  logic prev_ar = 1'b0, prev_rr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // slave drives at negedge; values then hold through the next posedge
  always @(negedge clk) begin
    arready = arvalid && (ar_wait >= ar_delay);
    ar_wait = arvalid ? ar_wait + 1 : 0;
    rvalid  = rready && (r_wait >= r_delay);
    r_wait  = rready ? r_wait + 1 : 0;
    rdata   = rvalid ? cfg_data : 32'h0;
    rresp   = rvalid ? cfg_resp : 2'b00;

    if (arvalid && !prev_ar) begin
      ar_rises++;
      ar_rise_cyc = cyc;
      ar_gap = cyc - r_hs_cyc;
      ar_len = 0;
    end
    if (arvalid) begin
      ar_len++;
      if (araddr !== ADDR || arprot !== 3'b000) addr_bad++;
    end
    if (rready && !prev_rr) r_len = 0;
    if (rready) r_len++;
    if (busy && !arvalid && !rready) rr_gap++;
    if (rvalid && rready) begin
      r_hs++;
      r_hs_cyc = cyc;
    end
    if (status_changed) chg_cnt++;
    if (rd_error) err_pulses++;
    prev_ar = arvalid;
    prev_rr = rready;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_rhs(input int n);
    int tgt;
    int k;
    tgt = r_hs + n;
    k = 0;
    while (r_hs < tgt && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("rhs_timeout", 64'(r_hs >= tgt), 64'd1);
  endtask

  task automatic wait_ar();
    int tgt;
    int k;
    tgt = ar_rises + 1;
    k = 0;
    while (ar_rises < tgt && k < 400) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("ar_timeout", 64'(ar_rises >= tgt), 64'd1);
  endtask

  task automatic pulse_poll();
    poll_now = 1'b1;
    step(1);
    poll_now = 1'b0;
  endtask

  int rel_cyc, base_ar, base_r, base_e, k;

  initial begin
    resetn = 1'b0;
    enable = 1'b1;
    poll_now = 1'b0;
    arready = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
    rresp = '0;
    step(3);
    check("rst_word", 64'(status_word), 64'h0);
    check("rst_valid", 64'(status_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_arvalid", 64'(arvalid), 64'h0);
    check("rst_errcnt", 64'(err_count), 64'h0);
    check("bready", 64'(bready), 64'h1);
    check("aw_w_tie", 64'({awvalid, wvalid, awaddr, wdata}), 64'h0);

    resetn = 1'b1;
    rel_cyc = cyc;
    wait_ar();
    check("first_ar_lat", 64'(ar_rise_cyc - rel_cyc), 64'd1);
    wait_rhs(1);
    check("first_rd_lat", 64'(r_hs_cyc - ar_rise_cyc), 64'd1);
    step(2);
    check("word_31", 64'(status_word), 64'h31);
    check("valid_1", 64'(status_valid), 64'h1);
    check("chg_once", 64'(chg_cnt), 64'd1);

    for (int i = 0; i < 3; i++) begin
      wait_ar();
      check("ar_period", 64'(ar_gap), 64'(PC + 1));
      wait_rhs(1);
    end
    step(2);
    check("same_no_chg", 64'(chg_cnt), 64'd1);

    ar_delay = 5;
    r_delay = 7;
    cfg_data = 32'h0001_0031;
    wait_rhs(1);
    step(2);
    check("word_10031", 64'(status_word), 64'h10031);
    check("chg_10031", 64'(chg_cnt), 64'd2);
    check("ar_len", 64'(ar_len), 64'd6);
    check("r_len", 64'(r_len), 64'd8);
    check("addr_stable", 64'(addr_bad), 64'd0);
    check("rready_held", 64'(rr_gap), 64'd0);

    ar_delay = 0;
    r_delay = 0;
    cfg_resp = RESP_SLVERR;
    cfg_data = 32'hdead_beef;
    base_e = err_pulses;
    wait_rhs(3);
    step(2);
    check("err_pulses3", 64'(err_pulses - base_e), 64'd3);
    check("err_cnt3", 64'(err_count), 64'd3);
    check("err_keep_word", 64'(status_word), 64'h10031);
    check("err_no_chg", 64'(chg_cnt), 64'd2);
    check("err2_cnt3", 64'(s2_cnt), 64'd3);
    wait_rhs(2);
    step(2);
    check("err_cnt5", 64'(err_count), 64'd5);
    check("err2_sat", 64'(s2_cnt), 64'd3);

    enable = 1'b0;
    cfg_resp = RESP_OKAY;
    cfg_data = 32'h55;
    r_delay = 3;
    base_ar = ar_rises;
    step(25);
    check("no_timer_poll", 64'(ar_rises - base_ar), 64'd0);
    base_ar = ar_rises;
    base_r = r_hs;
    pulse_poll();
    check("busy_after_pn", 64'(busy), 64'h1);
    pulse_poll();
    pulse_poll();
    step(60);
    check("pn_polls", 64'(ar_rises - base_ar), 64'd2);
    check("pn_reads", 64'(r_hs - base_r), 64'd2);
    check("word_55", 64'(status_word), 64'h55);
    check("chg_55", 64'(chg_cnt), 64'd3);

    r_delay = 10;
    pulse_poll();
    k = 0;
    while (!rready && k < 50) begin
      step(1);
      k++;
    end
    check("in_data", 64'(rready), 64'h1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_arvalid", 64'(arvalid), 64'h0);
    check("arst_rready", 64'(rready), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_word", 64'(status_word), 64'h0);
    check("arst_valid", 64'(status_valid), 64'h0);
    check("arst_errcnt", 64'(err_count), 64'h0);
    check("arst_pulses", 64'({status_changed, rd_error}), 64'h0);
    check("arst2_errcnt", 64'(s2_cnt), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_status_poller.md
Name: axi_status_poller

Overview:
- AXI4-Lite master that periodically reads one 32-bit status register from an AXI4-Lite slave, for example the QSFP/Aurora status-word slave.
- Presents the most recent good read as a parallel status word.
- Pulses when the word changes and counts read errors.
- Sits in fabric logic that needs link status without a CPU in the loop.
- Read-only master: the write channels are tied off.

Parameters:
- POLL_ADDR, 32'h0000_0000, AXI byte address that is read on every poll.
- POLL_CYCLES, 1000, clk cycles from the end of one poll to the start of the next. Range 1 to 2^24.
- ERR_W, 16, width of the saturating read-error counter.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, active-low, asserted asynchronously, released synchronously to clk
- enable  in  1  1 = periodic polling permitted
- poll_now  in  1  single-cycle request for an immediate poll
- status_word  out  32  last RDATA returned with RRESP=OKAY
- status_valid  out  1  1 once any good read has completed
- status_changed  out  1  one-cycle pulse when status_word is updated to a new value
- rd_error  out  1  one-cycle pulse on a read with RRESP other than OKAY
- err_count  out  ERR_W  saturating count of error reads
- busy  out  1  1 while a read is in flight
- M_AXI_ARADDR  out  32  constant POLL_ADDR
- M_AXI_ARVALID  out  1
- M_AXI_ARPROT  out  3  constant 3'b000
- M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  32
- M_AXI_RRESP  in  2
- M_AXI_RVALID  in  1
- M_AXI_RREADY  out  1
- M_AXI_AWADDR / AWVALID / AWPROT / WDATA / WSTRB / WVALID  out  constant 0
- M_AXI_AWREADY / WREADY / BRESP / BVALID  in  ignored
- M_AXI_BREADY  out  1  constant 1

Behaviour:
- Reset (resetn=0, asynchronous, all flops):
  - FSM to IDLE.
  - ARVALID=0, RREADY=0, status_word=0, status_valid=0.
  - status_changed=0, rd_error=0, err_count=0, busy=0.
  - Poll timer=0; pending=0.
- Poll timer: 24-bit down-counter.
  - Decrements by 1 each cycle while nonzero, in all states.
  - Loaded with POLL_CYCLES-1 on the cycle the R handshake completes.
- Trigger, evaluated in IDLE only: (enable && timer==0) || poll_now || pending.
- pending:
  - Set by poll_now while FSM is not IDLE.
  - Cleared when IDLE takes a trigger.
  - Holds at most one queued request; extra poll_now pulses while busy are merged.
- FSM states:
  - IDLE: on trigger, go to ADDR. ARVALID=1 and busy=1 from the next cycle.
  - ADDR: hold ARVALID=1 with ARADDR stable until the cycle where ARVALID && ARREADY. Next state DATA: ARVALID=0, RREADY=1.
  - DATA: hold RREADY=1 until the cycle where RVALID && RREADY. Then RREADY=0, busy=0, next state IDLE.
- DATA completion outcomes:
  - RRESP==2'b00: status_word<=RDATA and status_valid<=1. status_changed=1 for the following cycle iff status_valid was 0 or RDATA != old status_word.
  - RRESP!=2'b00: status_word unchanged; rd_error=1 for the following cycle; err_count+1, saturating at all-ones.
- Latency:
  - Poll start is 1 cycle from trigger to ARVALID.
  - With ARREADY=1 and RVALID=1 on their first opportunity, a full read takes 3 cycles from trigger to the status_word update.
  - No AXI timeout: the FSM waits indefinitely, as AXI forbids abandoning a transaction.
- enable deasserted mid-transaction: the transaction completes normally; the FSM then stays IDLE (poll_now still honoured).
- poll_now and timer expiry in the same cycle produce one poll.
- Only one outstanding read at any time.
- Reset mid-transaction: outputs drop immediately. The attached slave must be in the same reset domain.

Decomposition:
- Shared package axi_lite_pkg:
  - RRESP constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - FSM state encodings IDLE/ADDR/DATA.
- One natural sub-module: poll_timer, the reloadable saturating down-counter with a zero flag.
- The FSM and status registers stay in the top module.

Test Plan:
- Reset release, enable=1, POLL_CYCLES=8, slave returns 32'h0000_0031 OKAY with ARREADY/RVALID immediate:
  - ARVALID rises 1 cycle after reset release.
  - status_word=32'h31, status_valid=1, status_changed pulses once.
  - Next ARVALID 8 cycles after the R handshake.
- Slave returns the same value 32'h31 on consecutive polls -> status_changed stays 0; ARVALID repeats every 8 cycles after R completes.
- Slave returns 32'h10031 with ARREADY delayed 5 cycles and RVALID delayed 7 cycles:
  - ARADDR/ARVALID held stable through the wait.
  - RREADY=1 throughout.
  - status_word=32'h10031 with a status_changed pulse.
- Slave returns RRESP=SLVERR three times:
  - rd_error pulses 3 times, err_count=3, status_word retains its prior value.
  - With ERR_W=2, five errors leave err_count=3.
- enable=0; poll_now pulsed twice while busy:
  - Exactly one extra poll follows the current one.
  - No timer-driven polls occur.
- resetn asserted in the DATA state -> ARVALID/RREADY/busy go to 0 without waiting for clk; all outputs at reset values; err_count=0.
